// File: rtl/ahb_apb_wrap_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_wrap_bridge
//
// AHB-Lite slave to APB master bridge for SINGLE and WRAP4/8/16 word bursts.
// Each accepted AHB beat becomes one APB SETUP/ACCESS transfer. Beat
// addresses after the first one come from an internal wrap counter, so
// Haddr is only looked at on NONSEQ.
//
// Handshake: an AHB address phase is taken on a rising edge where
// Hreadyout=1, Hsel=1 and Htrans is NONSEQ/SEQ. Hreadyout then stays low
// until the APB completer finishes ACCESS with Pready=1. Pready is only
// looked at in ACCESS.
//
// Ports
//   Hclk, Hresetn        clock, asynchronous active-low reset
//   Hsel, Htrans, Haddr  AHB address phase (select, transfer type, address)
//   Hwrite, Hburst       AHB direction and burst type
//   Hwdata               AHB write data (sampled in the WDATA cycle)
//   Pready, Prdata       APB completer response
//   Hreadyout            1 = bridge idle, next address phase may be taken
//   Psel, Penable        APB control
//   Pwrite, Paddr, Pdata APB direction, address, write data
//   rdata_temp           last completed APB read data (AHB read data)
// ---------------------------------------------------------------------------
module ahb_apb_wrap_bridge (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hsel,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic        Hwrite,
    input  logic [1:0]  Hburst,
    input  logic [31:0] Hwdata,
    input  logic        Pready,
    input  logic [31:0] Prdata,
    output logic        Hreadyout,
    output logic        Psel,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pdata,
    output logic [31:0] rdata_temp
);

    // BUSY (2'b01) needs no decode: it starts nothing and keeps the burst.
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [1:0] BURST_SINGLE = 2'b00;
    localparam logic [1:0] BURST_WRAP4  = 2'b01;
    localparam logic [1:0] BURST_WRAP8  = 2'b10;
    localparam logic [1:0] BURST_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WDATA  = 2'd1,
        ST_SETUP  = 2'd2,
        ST_ACCESS = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Burst context
    logic [1:0]  burst_type;
    logic        burst_active;
    logic [3:0]  beat_cnt;      // index of the current beat within the burst

    logic        addr_phase;
    logic        start_nonseq;
    logic        start_seq;
    logic        clear_ctx;
    logic [31:0] wrap_mask;
    logic [3:0]  last_beat;
    logic [3:0]  beat_cnt_inc;
    logic [31:0] next_addr;

    // Address phases are only observed while the bridge is idle.
    assign addr_phase   = (state == ST_IDLE) && Hsel;
    assign start_nonseq = addr_phase && (Htrans == TRANS_NONSEQ);
    // A SEQ outside an active burst is dropped.
    assign start_seq    = addr_phase && (Htrans == TRANS_SEQ) && burst_active;
    assign clear_ctx    = (state == ST_IDLE) && (!Hsel || (Htrans == TRANS_IDLE));

    always_comb begin
        wrap_mask = 32'h0000_0000;
        last_beat = 4'd0;
        case (burst_type)
            BURST_WRAP4: begin
                wrap_mask = 32'h0000_000F;
                last_beat = 4'd3;
            end
            BURST_WRAP8: begin
                wrap_mask = 32'h0000_001F;
                last_beat = 4'd7;
            end
            BURST_WRAP16: begin
                wrap_mask = 32'h0000_003F;
                last_beat = 4'd15;
            end
            default: begin
                wrap_mask = 32'h0000_0000;
                last_beat = 4'd0;
            end
        endcase
    end

    // Increment inside the wrap window, keep the bits above it.
    assign next_addr    = (Paddr & ~wrap_mask) | ((Paddr + 32'd4) & wrap_mask);
    assign beat_cnt_inc = beat_cnt + 4'd1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Hreadyout  = 1'b0;
        Psel       = 1'b0;
        Penable    = 1'b0;
        case (state)
            ST_IDLE: begin
                Hreadyout = 1'b1;
                // SEQ beats follow the direction latched by their NONSEQ.
                if (start_nonseq) begin
                    state_next = Hwrite ? ST_WDATA : ST_SETUP;
                end else if (start_seq) begin
                    state_next = Pwrite ? ST_WDATA : ST_SETUP;
                end
            end
            ST_WDATA: begin
                state_next = ST_SETUP;
            end
            ST_SETUP: begin
                Psel       = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                Psel    = 1'b1;
                Penable = 1'b1;
                if (Pready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst context
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            burst_type   <= BURST_SINGLE;
            burst_active <= 1'b0;
            beat_cnt     <= 4'd0;
        end else if (start_nonseq) begin
            burst_type   <= Hburst;
            burst_active <= (Hburst != BURST_SINGLE);
            beat_cnt     <= 4'd0;
        end else if (start_seq) begin
            beat_cnt <= beat_cnt_inc;
            if (beat_cnt_inc == last_beat) begin
                burst_active <= 1'b0;
            end
        end else if (clear_ctx) begin
            burst_type   <= BURST_SINGLE;
            burst_active <= 1'b0;
            beat_cnt     <= 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // APB address/data path; everything holds between transfers.
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Paddr  <= 32'h0;
            Pwrite <= 1'b0;
        end else if (start_nonseq) begin
            Paddr  <= Haddr;
            Pwrite <= Hwrite;
        end else if (start_seq) begin
            Paddr  <= next_addr;
        end
    end

    // Hwdata is the data phase of the beat just accepted.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Pdata <= 32'h0;
        end else if (state == ST_WDATA) begin
            Pdata <= Hwdata;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            rdata_temp <= 32'h0;
        end else if ((state == ST_ACCESS) && Pready && !Pwrite) begin
            rdata_temp <= Prdata;
        end
    end

endmodule

// File: tb/tb_ahb_apb_wrap_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_wrap_bridge
//
// Directed bench for ahb_apb_wrap_bridge. A table of AHB beats, each with
// hand-computed APB address/direction/data and read data, is applied in
// order; every beat either must produce one APB transfer with the right
// cycle counts, or must leave the bridge idle with Paddr unchanged.
// Hand-written sequences cover reset values and reset during ACCESS.
// ---------------------------------------------------------------------------
module tb_ahb_apb_wrap_bridge;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    localparam logic [1:0] B_S   = 2'b00;
    localparam logic [1:0] B_W4  = 2'b01;
    localparam logic [1:0] B_W8  = 2'b10;
    localparam logic [1:0] B_W16 = 2'b11;

    logic        Hclk;
    logic        Hresetn;
    logic        Hsel;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [1:0]  Hburst;
    logic [31:0] Hwdata;
    logic        Pready;
    logic [31:0] Prdata;
    logic        Hreadyout;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pdata;
    logic [31:0] rdata_temp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic        hwrite;
        logic [1:0]  hburst;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        int          waits;
        logic        xfer;
        logic [31:0] exp_paddr;
        logic        exp_pwrite;
        logic [31:0] exp_pdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    ahb_apb_wrap_bridge dut (
        .Hclk       (Hclk),
        .Hresetn    (Hresetn),
        .Hsel       (Hsel),
        .Htrans     (Htrans),
        .Haddr      (Haddr),
        .Hwrite     (Hwrite),
        .Hburst     (Hburst),
        .Hwdata     (Hwdata),
        .Pready     (Pready),
        .Prdata     (Prdata),
        .Hreadyout  (Hreadyout),
        .Psel       (Psel),
        .Penable    (Penable),
        .Pwrite     (Pwrite),
        .Paddr      (Paddr),
        .Pdata      (Pdata),
        .rdata_temp (rdata_temp)
    );

    // ---------------- clock / reset ----------------
    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " Hreadyout"},  32'(Hreadyout), 32'd1);
        chk({tag, " Psel"},       32'(Psel),      32'd0);
        chk({tag, " Penable"},    32'(Penable),   32'd0);
        chk({tag, " Pwrite"},     32'(Pwrite),    32'd0);
        chk({tag, " Paddr"},      Paddr,          32'h0);
        chk({tag, " Pdata"},      Pdata,          32'h0);
        chk({tag, " rdata_temp"}, rdata_temp,     32'h0);
    endtask

    function automatic vec_t mk(input logic hsel, input logic [1:0] htrans,
                                input logic [31:0] haddr, input logic hwrite,
                                input logic [1:0] hburst, input logic [31:0] hwdata,
                                input logic [31:0] prdata, input int waits,
                                input logic xfer, input logic [31:0] exp_paddr,
                                input logic exp_pwrite, input logic [31:0] exp_pdata,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.hsel = hsel;
        v.htrans = htrans;
        v.haddr = haddr;
        v.hwrite = hwrite;
        v.hburst = hburst;
        v.hwdata = hwdata;
        v.prdata = prdata;
        v.waits = waits;
        v.xfer = xfer;
        v.exp_paddr = exp_paddr;
        v.exp_pwrite = exp_pwrite;
        v.exp_pdata = exp_pdata;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Called at a falling edge with Hreadyout=1; returns at a falling edge
    // with Hreadyout=1 so the next beat can be driven back-to-back.
    task automatic do_beat(input vec_t v, input int idx);
        int          low;
        int          psel_n;
        int          pen_n;
        int          acc;
        int          guard;
        int          exp_low;
        logic [31:0] setup_paddr;
        logic        stable;
        string       tag;
        tag    = $sformatf("v%0d", idx);
        Hsel   = v.hsel;
        Htrans = v.htrans;
        Haddr  = v.haddr;
        Hwrite = v.hwrite;
        Hburst = v.hburst;
        Hwdata = v.hwdata;
        Prdata = v.prdata;
        Pready = 1'b1;
        if (!v.xfer) begin
            @(negedge Hclk);
            chk({tag, " no-xfer Hreadyout"}, 32'(Hreadyout), 32'd1);
            chk({tag, " no-xfer Psel"},      32'(Psel),      32'd0);
            chk({tag, " no-xfer Paddr"},     Paddr,          v.exp_paddr);
        end else begin
            low = 0;
            psel_n = 0;
            pen_n = 0;
            acc = 0;
            guard = 0;
            setup_paddr = 32'hxxxx_xxxx;
            stable = 1'b1;
            @(negedge Hclk);
            while (Hreadyout !== 1'b1 && guard < 40) begin
                guard++;
                low++;
                if (Psel) psel_n++;
                if (Psel && !Penable) setup_paddr = Paddr;
                if (Penable) begin
                    pen_n++;
                    acc++;
                    if (Paddr !== setup_paddr) stable = 1'b0;
                    Pready = (acc > v.waits);
                end else begin
                    Pready = 1'b1;
                end
                @(negedge Hclk);
            end
            exp_low = (v.exp_pwrite ? 3 : 2) + v.waits;
            chk({tag, " completed"},        32'(Hreadyout), 32'd1);
            chk({tag, " hreadyout-low"},    32'(low),       32'(exp_low));
            chk({tag, " psel-cycles"},      32'(psel_n),    32'(2 + v.waits));
            chk({tag, " penable-cycles"},   32'(pen_n),     32'(1 + v.waits));
            chk({tag, " setup Paddr"},      setup_paddr,    v.exp_paddr);
            chk({tag, " Paddr stable"},     32'(stable),    32'd1);
            chk({tag, " Paddr held"},       Paddr,          v.exp_paddr);
            chk({tag, " Pwrite"},           32'(Pwrite),    32'(v.exp_pwrite));
            chk({tag, " Pdata"},            Pdata,          v.exp_pdata);
            chk({tag, " rdata_temp"},       rdata_temp,     v.exp_rdata);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int guard;

        // Vector table: hsel, htrans, haddr, hwrite, hburst, hwdata, prdata,
        // waits, xfer, exp_paddr, exp_pwrite, exp_pdata, exp_rdata
        // SINGLE write
        vecs.push_back(mk(1'b1, NS, 32'h100, 1'b1, B_S, 32'hDEADBEEF, 32'h0, 0, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1'b1, ID, 32'h0, 1'b0, B_S, 32'h0, 32'h0, 0, 1'b0, 32'h100, 1'b1, 32'hDEADBEEF, 32'h0));
        // WRAP4 write from 0x38; SEQ Haddr is junk and must be ignored
        vecs.push_back(mk(1'b1, NS, 32'h38, 1'b1, B_W4, 32'h11111111, 32'h0, 0, 1'b1, 32'h38, 1'b1, 32'h11111111, 32'h0));
        vecs.push_back(mk(1'b1, SQ, 32'hABCD0000, 1'b1, B_W4, 32'h22222222, 32'h0, 0, 1'b1, 32'h3C, 1'b1, 32'h22222222, 32'h0));
        vecs.push_back(mk(1'b1, SQ, 32'h00000FF0, 1'b1, B_W4, 32'h33333333, 32'h0, 0, 1'b1, 32'h30, 1'b1, 32'h33333333, 32'h0));
        vecs.push_back(mk(1'b1, SQ, 32'h77777774, 1'b1, B_W4, 32'h44444444, 32'h0, 0, 1'b1, 32'h34, 1'b1, 32'h44444444, 32'h0));
        // fifth SEQ after a finished WRAP4: dropped
        vecs.push_back(mk(1'b1, SQ, 32'h00000040, 1'b1, B_W4, 32'h55555555, 32'h0, 0, 1'b0, 32'h34, 1'b1, 32'h44444444, 32'h0));
        vecs.push_back(mk(1'b1, ID, 32'h0, 1'b0, B_S, 32'h0, 32'h0, 0, 1'b0, 32'h34, 1'b1, 32'h44444444, 32'h0));
        // WRAP8 read from 0x1C, Prdata = beat index
        vecs.push_back(mk(1'b1, NS, 32'h1C, 1'b0, B_W8, 32'h0, 32'h0, 0, 1'b1, 32'h1C, 1'b0, 32'h44444444, 32'h0));
        for (int i = 1; i < 8; i++) begin
            vecs.push_back(mk(1'b1, SQ, 32'h90000000 + 32'(i), 1'b0, B_W8, 32'h0, 32'(i), 0, 1'b1,
                              32'((i - 1) * 4), 1'b0, 32'h44444444, 32'(i)));
        end
        vecs.push_back(mk(1'b1, ID, 32'h0, 1'b0, B_S, 32'h0, 32'h0, 0, 1'b0, 32'h18, 1'b0, 32'h44444444, 32'h7));
        // read with three wait states
        vecs.push_back(mk(1'b1, NS, 32'h40, 1'b0, B_S, 32'h0, 32'hA5A5A5A5, 3, 1'b1, 32'h40, 1'b0, 32'h44444444, 32'hA5A5A5A5));
        // write with one wait state and live Prdata: rdata_temp must hold
        vecs.push_back(mk(1'b1, NS, 32'h200, 1'b1, B_S, 32'h5A5A0001, 32'h12345678, 1, 1'b1, 32'h200, 1'b1, 32'h5A5A0001, 32'hA5A5A5A5));
        // WRAP4 from 0x08 with BUSY after beat 1
        vecs.push_back(mk(1'b1, NS, 32'h08, 1'b1, B_W4, 32'h00000008, 32'h0, 0, 1'b1, 32'h08, 1'b1, 32'h00000008, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b1, BZ, 32'hFFFFFFF0, 1'b1, B_W4, 32'h00000099, 32'h0, 0, 1'b0, 32'h08, 1'b1, 32'h00000008, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b1, SQ, 32'h0, 1'b1, B_W4, 32'h0000000C, 32'h0, 0, 1'b1, 32'h0C, 1'b1, 32'h0000000C, 32'hA5A5A5A5));
        // IDLE mid-burst, then SEQ: dropped
        vecs.push_back(mk(1'b1, ID, 32'h0, 1'b0, B_S, 32'h0, 32'h0, 0, 1'b0, 32'h0C, 1'b1, 32'h0000000C, 32'hA5A5A5A5));
        vecs.push_back(mk(1'b1, SQ, 32'h0, 1'b1, B_W4, 32'h0000000D, 32'h0, 0, 1'b0, 32'h0C, 1'b1, 32'h0000000C, 32'hA5A5A5A5));
        // NONSEQ without Hsel: dropped
        vecs.push_back(mk(1'b0, NS, 32'h300, 1'b1, B_S, 32'h0000000E, 32'h0, 0, 1'b0, 32'h0C, 1'b1, 32'h0000000C, 32'hA5A5A5A5));
        // WRAP16 read from 0x3C wraps to 0x00; then Hsel=0 clears the burst
        vecs.push_back(mk(1'b1, NS, 32'h3C, 1'b0, B_W16, 32'h0, 32'h16, 0, 1'b1, 32'h3C, 1'b0, 32'h0000000C, 32'h16));
        vecs.push_back(mk(1'b1, SQ, 32'h0, 1'b0, B_W16, 32'h0, 32'h17, 2, 1'b1, 32'h00, 1'b0, 32'h0000000C, 32'h17));
        vecs.push_back(mk(1'b0, SQ, 32'h0, 1'b0, B_W16, 32'h0, 32'h18, 0, 1'b0, 32'h00, 1'b0, 32'h0000000C, 32'h17));
        vecs.push_back(mk(1'b1, SQ, 32'h0, 1'b0, B_W16, 32'h0, 32'h19, 0, 1'b0, 32'h00, 1'b0, 32'h0000000C, 32'h17));
        vecs.push_back(mk(1'b1, ID, 32'h0, 1'b0, B_S, 32'h0, 32'h0, 0, 1'b0, 32'h00, 1'b0, 32'h0000000C, 32'h17));

        // Reset held while inputs toggle
        Hresetn = 1'b0;
        Hsel = 1'b0; Htrans = ID; Haddr = 32'h0; Hwrite = 1'b0;
        Hburst = B_S; Hwdata = 32'h0; Pready = 1'b0; Prdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Hclk);
            Hsel = 1'b1; Htrans = (i % 2 == 0) ? NS : SQ; Haddr = 32'h1000 + 32'(i * 4);
            Hwrite = i[0]; Hburst = 2'(i); Hwdata = 32'hFFFF0000 + 32'(i);
            Pready = ~Pready; Prdata = 32'hC0DE0000 + 32'(i);
        end
        @(negedge Hclk);
        chk_reset_values("reset");
        Hsel = 1'b0; Htrans = ID; Pready = 1'b1;
        Hresetn = 1'b1;
        @(negedge Hclk);
        chk_reset_values("post-reset");

        foreach (vecs[i]) begin
            do_beat(vecs[i], i);
        end

        // Reset asserted during ACCESS aborts the read immediately.
        Hsel = 1'b1; Htrans = NS; Haddr = 32'h500; Hwrite = 1'b0; Hburst = B_S;
        Prdata = 32'hBAD0BAD0; Pready = 1'b0;
        guard = 0;
        @(negedge Hclk);
        Htrans = ID;
        while (Penable !== 1'b1 && guard < 10) begin
            guard++;
            @(negedge Hclk);
        end
        chk("mid-access reached ACCESS", 32'(Penable), 32'd1);
        #2;
        Hresetn = 1'b0;
        Pready = 1'b1;
        #1;
        chk_reset_values("async-reset");
        @(negedge Hclk);
        Hresetn = 1'b1;
        @(negedge Hclk);
        chk_reset_values("after-abort");

        // Recovery: a plain read after the aborted one
        do_beat(mk(1'b1, NS, 32'h600, 1'b0, B_S, 32'h0, 32'hCAFEF00D, 0, 1'b1, 32'h600, 1'b0, 32'h0, 32'hCAFEF00D), 100);
        Hsel = 1'b0; Htrans = ID;
        @(negedge Hclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_apb_wrap_bridge.md
# ahb_apb_wrap_bridge

Single-clock AHB-Lite slave to APB master bridge supporting SINGLE and WRAP bursts. It accepts AHB address/data phases, generates the wrapping beat address sequence internally, and performs one APB SETUP/ACCESS transfer per beat. Hreadyout stalls the AHB master until each APB transfer completes. It sits between the system AHB interconnect and a single APB peripheral.

## Interface
Parameters: none. Data and address width are fixed at 32 bits, and transfers are word-sized only.

- Hclk  in  1  bridge clock, rising-edge; single clock shared by the AHB and APB sides
- Hresetn  in  1  asynchronous, active-low reset
- Hsel  in  1  slave select
- Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- Haddr  in  32  byte address; used only on NONSEQ
- Hwrite  in  1  1 = write
- Hburst  in  2  00 SINGLE, 01 WRAP4, 10 WRAP8, 11 WRAP16
- Hwdata  in  32  write data, valid in data phase
- Pready  in  1  APB completer ready
- Prdata  in  32  APB read data
- Hreadyout  out  1  1 = bridge can accept an address phase / data phase done
- Psel  out  1  APB select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Paddr  out  32  APB address
- Pdata  out  32  APB write data
- rdata_temp  out  32  last APB read data, returned to AHB as read data

Clock/reset: one clock; reset is asynchronous and active-low (Hclk, Hresetn).

## Operation
- Valid beat: a rising edge with Hreadyout=1, Hsel=1, and Htrans ∈ {NONSEQ, SEQ}. Under any other condition, no transfer starts.
- NONSEQ beat:
  - Latch Haddr as Paddr, Hwrite as Pwrite, and Hburst as the burst type.
  - Clear the beat counter and mark the burst active (unless SINGLE).
- SEQ beat (burst active only):
  - Ignore Haddr.
  - Paddr ← (Paddr & ~M) | ((Paddr + 4) & M), where M = 0xF for WRAP4, 0x1F for WRAP8, 0x3F for WRAP16.
  - Increment the beat counter.
- SEQ with no burst active (after SINGLE, after the final beat, or after IDLE): ignored, no APB transfer.
- Burst completion: the burst goes inactive once beat count = 4/8/16.
- BUSY: no transfer; burst context retained.
- IDLE, or Hsel=0 with Hreadyout=1: burst context cleared.
- FSM states:
  - IDLE: Hreadyout=1, Psel=0, Penable=0. A valid write goes to WDATA; a valid read goes to SETUP.
  - WDATA: Hreadyout=0, Psel=0. Pdata ← Hwdata at the exiting edge. Next state SETUP.
  - SETUP: Psel=1, Penable=0, Hreadyout=0. Next state ACCESS.
  - ACCESS: Psel=1, Penable=1, Hreadyout=0. Stays while Pready=0. On Pready=1:
    - if Pwrite=0, rdata_temp ← Prdata;
    - then go to IDLE (Psel=0, Penable=0, Hreadyout=1).
- Paddr, Pwrite and Pdata stay stable from SETUP through ACCESS completion and hold their values afterwards.
- rdata_temp holds until the next completed read. A write never changes it.

## Timing
- Reset values (async, immediate): state IDLE, Hreadyout=1, Psel=0, Penable=0, Pwrite=0, Paddr=0, Pdata=0, rdata_temp=0, burst inactive, beat counter 0.
- Reset asserted mid-transfer aborts the transfer with no completion. Outputs take reset values at once.
- Write latency with Pready=1: Hreadyout is low for exactly 3 cycles (WDATA, SETUP, ACCESS), and Psel is high for 2 cycles.
- Read latency with Pready=1: Hreadyout is low for 2 cycles. rdata_temp is valid in the cycle Hreadyout returns to 1.
- Each cycle with Pready=0 in ACCESS adds one cycle of Hreadyout=0.
- Hreadyout is 1 for at least one cycle between beats. The next beat's address phase is sampled in that cycle, giving back-to-back throughput.
- Pready is ignored outside ACCESS.

## Test plan
- Reset: hold Hresetn=0, then toggle all inputs -> every output at its reset value; Hreadyout=1.
- SINGLE write, Pready=1: NONSEQ Haddr=0x100, Hwrite=1, Hwdata=0xDEADBEEF -> Paddr=0x100, Pdata=0xDEADBEEF, Pwrite=1; Psel 2 cycles, Penable in the 2nd; Hreadyout low 3 cycles.
- WRAP4 write, start 0x38:
  - Drive NONSEQ, then 3 SEQ beats with random Haddr.
  - -> Paddr sequence 0x38, 0x3C, 0x30, 0x34.
  - A 5th SEQ produces no Psel.
- WRAP8 read, start 0x1C, Prdata=beat index -> Paddr sequence 0x1C, 0x00, 0x04, …, 0x18. rdata_temp updates after each ACCESS; Pwrite=0, and no WDATA state occurs.
- Wait states:
  - Read at 0x40 with Pready=0 for 3 ACCESS cycles, then Prdata=0xA5A5A5A5 with Pready=1.
  - -> Penable high 4 cycles, Hreadyout low 5 cycles.
  - rdata_temp=0xA5A5A5A5.
- BUSY/IDLE/Hsel:
  - WRAP4 from 0x08 with a BUSY inserted after beat 1 -> the next SEQ is 0x0C.
  - IDLE mid-burst, then SEQ -> no transfer.
  - NONSEQ with Hsel=0 -> no transfer.
  - Hresetn pulsed during ACCESS -> immediate reset values.
